// File: rtl/pin_bus_arbiter.sv
// Round-robin arbiter sharing one registered master-side pin bus among NUM_REQ requesters.
// Each grant runs IDLE -> BUSY (until ack/err/timeout) -> DONE, returning a one-cycle completion pulse.
module pin_bus_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DW         = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            m_req,
    input  logic [NUM_REQ-1:0]            m_rw,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] m_address,
    input  logic [NUM_REQ*DW-1:0]         m_wr_data,
    output logic [NUM_REQ-1:0]            m_ack,
    output logic [NUM_REQ-1:0]            m_err,
    output logic [DW-1:0]                 m_rd_data,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
    output logic                          busy,
    output logic [ADDR_WIDTH-1:0]         address,
    output logic [DW-1:0]                 wr_data,
    output logic                          rw,
    output logic                          req,
    input  logic [DW-1:0]                 rd_data,
    input  logic                          ack,
    input  logic                          err
);
    localparam int          GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int          TW = $clog2(TIMEOUT + 1);
    localparam int unsigned NR = NUM_REQ;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] win;
    logic [GW-1:0] cand;
    logic          found;
    logic [TW-1:0] timer;
    logic          timeout_hit;
    int unsigned   idx;

    // Search starts one past the last winner so a continuous requester cannot starve others.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned off = 1; off <= NR; off++) begin
            idx = 32'(last_grant) + off;
            if (idx >= NR) idx = idx - NR;
            cand = GW'(idx);
            if (!found && m_req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign timeout_hit = (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GW'(NUM_REQ - 1);
            grant_id   <= '0;
            timer      <= '0;
            busy       <= 1'b0;
            req        <= 1'b0;
            rw         <= 1'b0;
            address    <= '0;
            wr_data    <= '0;
            m_ack      <= '0;
            m_err      <= '0;
            m_rd_data  <= '0;
        end else begin
            m_ack <= '0;
            m_err <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        address    <= m_address[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                        wr_data    <= m_wr_data[int'(win)*DW +: DW];
                        rw         <= m_rw[win];
                        req        <= 1'b1;
                        grant_id   <= win;
                        last_grant <= win;
                        timer      <= '0;
                        busy       <= 1'b1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    timer <= timer + 1'b1;
                    if (err || timeout_hit) begin
                        req             <= 1'b0;
                        m_err[grant_id] <= 1'b1;
                        state           <= DONE;
                    end else if (ack) begin
                        req             <= 1'b0;
                        m_ack[grant_id] <= 1'b1;
                        if (!rw) m_rd_data <= rd_data;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    req   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pin_bus_arbiter.sv
// Scoreboard bench for pin_bus_arbiter: expected completions are queued when the slave
// response is driven and popped when the requester-side pulse appears.
module tb_pin_bus_arbiter;
    localparam int NR = 2;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    m_req, m_rw, m_ack, m_err;
    logic [NR*AW-1:0] m_address;
    logic [NR*DW-1:0] m_wr_data;
    logic [DW-1:0]    m_rd_data, wr_data, rd_data;
    logic [0:0]       grant_id;
    logic             busy, rw, req, ack, err;
    logic [AW-1:0]    address;

    typedef struct {
        logic [NR-1:0] ack;
        logic [NR-1:0] err;
        logic [DW-1:0] rd;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         passed = 0;
    int         total  = 0;
    logic [0:0] rr_last;
    logic [DW-1:0] exp_rd;

    pin_bus_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_rw(m_rw), .m_address(m_address),
        .m_wr_data(m_wr_data), .m_ack(m_ack), .m_err(m_err), .m_rd_data(m_rd_data),
        .grant_id(grant_id), .busy(busy), .address(address), .wr_data(wr_data),
        .rw(rw), .req(req), .rd_data(rd_data), .ack(ack), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic clear_inputs();
        m_req = '0; m_rw = '0; m_address = '0; m_wr_data = '0;
        ack = 1'b0; err = 1'b0; rd_data = '0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req) begin ok = 1'b1; break; end
        end
    endtask

    task automatic respond(input int gap, input bit a, input bit ev, input logic [DW-1:0] rd,
                           output logic [NR-1:0] oa, output logic [NR-1:0] oe,
                           output logic [DW-1:0] ord);
        repeat (gap) @(negedge clk);
        ack = a; err = ev; rd_data = rd;
        @(negedge clk);
        oa = m_ack; oe = m_err; ord = m_rd_data;
        ack = 1'b0; err = 1'b0; rd_data = '0;
    endtask

    function automatic logic [0:0] rr_pick(input logic [NR-1:0] mask, input logic [0:0] last);
        int c;
        for (int k = 1; k <= NR; k++) begin
            c = (int'(last) + k) % NR;
            if (mask[c]) return 1'(c);
        end
        return last;
    endfunction

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        total++; if (req !== 1'b0) $display("FAIL reset_req: got %b want 0", req); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if ({m_ack, m_err} !== 4'b0) $display("FAIL reset_pulses: got %b want 0000", {m_ack, m_err}); else passed++;
        total++; if ({address, wr_data, rw, grant_id, m_rd_data} !== 34'b0)
            $display("FAIL reset_bus: got %h want 0", {address, wr_data, rw, grant_id, m_rd_data}); else passed++;
        rst = 1'b0;
        rr_last = 1'b1;
        exp_rd  = '0;
    endtask

    task automatic test_single_write();
        logic [NR-1:0] oa, oe;
        logic [DW-1:0] ord;
        m_req[0] = 1'b1; m_rw[0] = 1'b1;
        m_address[0 +: AW] = 16'h1234; m_wr_data[0 +: DW] = 8'hA5;
        @(negedge clk);
        total++; if (req !== 1'b1) $display("FAIL write_req_latency: got %b want 1", req); else passed++;
        total++; if ({address, wr_data, rw} !== {16'h1234, 8'hA5, 1'b1})
            $display("FAIL write_bus: got %h/%h/%b want 1234/a5/1", address, wr_data, rw); else passed++;
        sb.push_back('{ack: 2'b01, err: 2'b00, rd: exp_rd});
        respond(1, 1'b1, 1'b0, 8'hEE, oa, oe, ord);
        m_req = '0;
        e = sb.pop_front();
        total++; if ({oa, oe, ord} !== {e.ack, e.err, e.rd})
            $display("FAIL write_completion: got ack=%b err=%b rd=%h want ack=%b err=%b rd=%h", oa, oe, ord, e.ack, e.err, e.rd); else passed++;
        @(negedge clk);
        total++; if ({busy, req, m_ack} !== 4'b0) $display("FAIL write_after_done: got busy=%b req=%b ack=%b want 0", busy, req, m_ack); else passed++;
        rr_last = 1'b0;
    endtask

    task automatic test_read_data();
        logic [NR-1:0] oa, oe;
        logic [DW-1:0] ord;
        bit ok;
        m_req[1] = 1'b1; m_rw[1] = 1'b0; m_address[AW +: AW] = 16'h0010;
        wait_req(ok);
        total++; if (!ok) $display("FAIL read_req_wait: got timeout want req"); else passed++;
        total++; if ({address, rw, grant_id} !== {16'h0010, 1'b0, 1'b1})
            $display("FAIL read_bus: got %h/%b/%0d want 0010/0/1", address, rw, grant_id); else passed++;
        exp_rd = 8'h3C;
        sb.push_back('{ack: 2'b10, err: 2'b00, rd: exp_rd});
        respond(0, 1'b1, 1'b0, 8'h3C, oa, oe, ord);
        m_req = '0;
        e = sb.pop_front();
        total++; if ({oa, oe, ord} !== {e.ack, e.err, e.rd})
            $display("FAIL read_completion: got ack=%b err=%b rd=%h want ack=%b err=%b rd=%h", oa, oe, ord, e.ack, e.err, e.rd); else passed++;
        @(negedge clk);
        rr_last = 1'b1;
    endtask

    task automatic test_contention();
        logic [NR-1:0] oa, oe;
        logic [DW-1:0] ord;
        logic [0:0] g;
        int cnt [NR];
        bit ok;
        cnt[0] = 0; cnt[1] = 0;
        m_rw = 2'b11;
        m_address = {16'hBBBB, 16'hAAAA};
        m_wr_data = {8'h22, 8'h11};
        m_req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_req(ok);
            g = rr_pick(2'b11, rr_last);
            rr_last = g;
            total++; if (!ok || grant_id !== g || address !== m_address[int'(g)*AW +: AW])
                $display("FAIL contention_grant%0d: got ok=%b id=%0d addr=%h want id=%0d", t, ok, grant_id, address, g); else passed++;
            sb.push_back('{ack: 2'(1 << g), err: 2'b00, rd: exp_rd});
            respond(0, 1'b1, 1'b0, 8'h99, oa, oe, ord);
            e = sb.pop_front();
            total++; if ({oa, oe, ord} !== {e.ack, e.err, e.rd})
                $display("FAIL contention_completion%0d: got ack=%b err=%b rd=%h want ack=%b err=%b", t, oa, oe, ord, e.ack, e.err); else passed++;
            cnt[g] += int'(oa[g]);
        end
        m_req = '0;
        total++; if (cnt[0] != 2 || cnt[1] != 2)
            $display("FAIL contention_fairness: got %0d/%0d acks want 2/2", cnt[0], cnt[1]); else passed++;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        logic [NR-1:0] oa, oe;
        logic [DW-1:0] ord;
        int n;
        bit ok;
        m_rw = 2'b00; m_req = 2'b01;
        sb.push_back('{ack: 2'b00, err: 2'b01, rd: exp_rd});
        wait_req(ok);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!req) break;
            n++;
        end
        total++; if (n != TO) $display("FAIL timeout_req_cycles: got %0d want %0d", n, TO); else passed++;
        e = sb.pop_front();
        total++; if ({m_ack, m_err, m_rd_data} !== {e.ack, e.err, e.rd})
            $display("FAIL timeout_completion: got ack=%b err=%b rd=%h want ack=%b err=%b rd=%h", m_ack, m_err, m_rd_data, e.ack, e.err, e.rd); else passed++;
        m_req = 2'b10; m_rw = 2'b10;
        rr_last = 1'b0;
        wait_req(ok);
        total++; if (!ok || grant_id !== 1'b1) $display("FAIL timeout_next_grant: got ok=%b id=%0d want 1", ok, grant_id); else passed++;
        sb.push_back('{ack: 2'b10, err: 2'b00, rd: exp_rd});
        respond(0, 1'b1, 1'b0, 8'h00, oa, oe, ord);
        m_req = '0;
        e = sb.pop_front();
        total++; if ({oa, oe} !== {e.ack, e.err}) $display("FAIL timeout_next_completion: got ack=%b err=%b want ack=%b err=%b", oa, oe, e.ack, e.err); else passed++;
        rr_last = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ack_err();
        logic [NR-1:0] oa, oe;
        logic [DW-1:0] ord;
        bit ok;
        m_rw = 2'b00; m_req = 2'b01;
        wait_req(ok);
        sb.push_back('{ack: 2'b00, err: 2'b01, rd: exp_rd});
        respond(0, 1'b1, 1'b1, 8'h77, oa, oe, ord);
        m_req = '0;
        e = sb.pop_front();
        total++; if ({oa, oe, ord} !== {e.ack, e.err, e.rd})
            $display("FAIL ack_err_priority: got ack=%b err=%b rd=%h want ack=%b err=%b rd=%h", oa, oe, ord, e.ack, e.err, e.rd); else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [NR-1:0] oa, oe;
        logic [DW-1:0] ord;
        bit ok;
        m_rw = 2'b00; m_req = 2'b01;
        wait_req(ok);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if ({req, busy, m_ack, m_err} !== 6'b0)
            $display("FAIL reset_mid_async: got req=%b busy=%b ack=%b err=%b want 0", req, busy, m_ack, m_err); else passed++;
        m_req = 2'b11;
        @(negedge clk);
        total++; if ({req, m_ack, m_err} !== 5'b0) $display("FAIL reset_mid_no_pulse: got req=%b ack=%b err=%b want 0", req, m_ack, m_err); else passed++;
        rst = 1'b0;
        wait_req(ok);
        total++; if (!ok || grant_id !== 1'b0) $display("FAIL reset_mid_restart: got ok=%b id=%0d want 0", ok, grant_id); else passed++;
        m_req = 2'b00;
        sb.push_back('{ack: 2'b01, err: 2'b00, rd: 8'h00});
        respond(0, 1'b1, 1'b0, 8'h00, oa, oe, ord);
        e = sb.pop_front();
        total++; if ({oa, oe, ord} !== {e.ack, e.err, e.rd})
            $display("FAIL reset_mid_completion: got ack=%b err=%b rd=%h want ack=%b err=%b rd=%h", oa, oe, ord, e.ack, e.err, e.rd); else passed++;
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_write();
        test_read_data();
        test_reset();
        test_contention();
        exp_rd = '0;
        test_timeout();
        exp_rd = 8'h00;
        test_ack_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
